// File: rtl/neuron_activation_stage.sv
// Neuron activation stage: accumulates N_TERMS signed partial sums plus a bias, then
// saturates to DATA_W bits and applies ReLU / leaky-ReLU into one registered result.
module neuron_activation_stage #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAC_W     = 10,
  parameter int unsigned N_TERMS    = 4,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned LEAKY      = 0,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Reject configurations where the accumulator could wrap or the format is meaningless.
  generate
    if (N_TERMS == 0 || ACC_W <= DATA_W + CNT_W || FRAC_W >= DATA_W) begin : g_bad_params
      $error("neuron_activation_stage: invalid parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ACT   = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0]  in_ext_c;
  logic signed [ACC_W-1:0]  bias_ext_c;
  logic signed [DATA_W-1:0] sat_c;
  logic                     sat_flag_c;
  logic [DATA_W-1:0]        act_c;

  assign in_ext_c   = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign bias_ext_c = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};

  // Clamp the accumulator into DATA_W bits, then apply the activation.
  always_comb begin
    sat_flag_c = 1'b0;
    sat_c      = DATA_W'(acc_q);
    if (acc_q > SAT_MAX) begin
      sat_c      = DATA_W'(SAT_MAX);
      sat_flag_c = 1'b1;
    end else if (acc_q < SAT_MIN) begin
      sat_c      = DATA_W'(SAT_MIN);
      sat_flag_c = 1'b1;
    end

    act_c = '0;
    if (!sat_c[DATA_W-1]) begin
      act_c = sat_c;
    end else if (LEAKY != 0) begin
      act_c = sat_c >>> LEAK_SHIFT;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = bias_ext_c + in_ext_c;
          cnt_d   = CNT_W'(1);
          state_d = (cnt_d == CNT_W'(N_TERMS)) ? ACT : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + in_ext_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(N_TERMS)) begin
            state_d = ACT;
          end
        end
      end
      ACT: begin
        out_valid_d = 1'b1;
        out_data_d  = act_c;
        out_sat_d   = sat_flag_c;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
